sram_price_streamer: RTL and testbench
======================================

Name: sram_price_streamer

Overview:
- Reader side of the price SRAM: walks an address window of the on-chip SRAM and replays each stored 32-bit price as a stock_price / data_ready stream.
- The stream drives the average computational block directly, so recorded price histories can be replayed through it.
- Owns the SRAM read port only: read_enable, address, read_data. Never writes.

Parameters:
ADDR_BITS, 5, SRAM address width; window arithmetic is modulo 2^ADDR_BITS
DATA_BITS, 32, price word width
GAP_CYCLES, 0, idle cycles inserted between consecutive data_ready pulses (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin streaming; sampled in IDLE only
start_address  input  ADDR_BITS  first SRAM word; latched on accepted start
last_address  input  ADDR_BITS  final SRAM word, inclusive; latched on accepted start
sram_read_enable  output  1  SRAM read strobe
sram_address  output  ADDR_BITS  SRAM word address
sram_read_data  input  DATA_BITS  SRAM data; valid in the cycle after the address is first presented, while read_enable stays high
stock_price  output  DATA_BITS  replayed price; holds its value between pulses
data_ready  output  1  one-cycle strobe: stock_price is new
busy  output  1  high from the cycle after an accepted start through the DONE state
done  output  1  one-cycle strobe at end of window

Behaviour:
- Reset: clears every output to 0 and forces IDLE, asynchronously. sram_read_enable drops immediately. A reset mid-window abandons the window; no done pulse.
- Control is a state machine: IDLE, READ, CAPTURE, GAP, DONE. All outputs are registered.
- IDLE:
  - start=1 latches both addresses and sets addr=start_address.
  - Next state is READ; busy=1 from that cycle.
  - start is ignored in every other state.
- READ: sram_read_enable=1, sram_address=addr. Next state is CAPTURE.
- CAPTURE:
  - sram_read_enable stays 1 and sram_address stays at addr.
  - sram_read_data is registered into stock_price; data_ready=1 in the following cycle.
  - If addr==last: next state is DONE.
  - Otherwise addr increments modulo 2^ADDR_BITS; next state is GAP if GAP_CYCLES>0, else READ.
- GAP: counts GAP_CYCLES cycles with read_enable=0, then goes to READ.
- DONE: done=1 for one cycle, coincident with the final data_ready. busy=0 afterwards. Next state is IDLE.
- Timing:
  - start accepted at cycle 0 gives the first data_ready at cycle 3.
  - Pulse period is 2+GAP_CYCLES cycles.
  - A new start is accepted no earlier than the cycle after done.
- Word count = ((last-start) mod 2^ADDR_BITS)+1.
  - start==last gives exactly one word.
  - last<start wraps through address 2^ADDR_BITS-1 to 0.
  - The full window (last = start-1) gives 2^ADDR_BITS words.
- sram_address is 0 whenever sram_read_enable is 0.
- start held high continuously restarts the window after each DONE→IDLE step.

Optional Feature:
- Macro: PRICE_STREAM_SUM_EN.
- Defined:
  - Adds output stream_sum [DATA_BITS+ADDR_BITS-1:0].
  - Reset value is 0. Cleared on an accepted start.
  - Accumulates each emitted stock_price in the same cycle data_ready is high.
  - Holds its value after done.
  - The bench uses it as the golden total for checking the average.
- Undefined: no port and no accumulator logic.

Test Plan:
- Single word: SRAM[3]=0x0000_1234, start=3, last=3 → one data_ready at cycle 3 with stock_price=0x1234; done in the same cycle; busy low after.
- Linear window: SRAM[0..3]=10,20,30,40, GAP_CYCLES=0 → data_ready at cycles 3,5,7,9 with prices 10,20,30,40 in order; done at cycle 9.
- Wrap-around: start=30, last=1, SRAM[30,31,0,1]=A,B,C,D → four pulses A,B,C,D; sram_address sequence 30,31,0,1.
- Pacing: GAP_CYCLES=3, window 0..1 → pulse spacing 5 cycles; read_enable low for the 3 gap cycles.
- Reset mid-stream: assert rst after the 2nd of 4 pulses → outputs 0 the same cycle; no further data_ready or done. After release, a new start replays from start_address.
- Sum (PRICE_STREAM_SUM_EN): window 0..3 with prices 10,20,30,40 → stream_sum=100 at done. Restarting the same window gives 100 again, not 200.

Source files
------------

// File: rtl/sram_price_streamer.sv
// sram_price_streamer: replays an SRAM address window as a stock_price/data_ready stream.
// Optional running total output stream_sum when PRICE_STREAM_SUM_EN is defined.
module sram_price_streamer #(
    parameter int ADDR_BITS  = 5,
    parameter int DATA_BITS  = 32,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_address,
    input  logic [ADDR_BITS-1:0] last_address,
    output logic                 sram_read_enable,
    output logic [ADDR_BITS-1:0] sram_address,
    input  logic [DATA_BITS-1:0] sram_read_data,
    output logic [DATA_BITS-1:0] stock_price,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 done
`ifdef PRICE_STREAM_SUM_EN
    ,
    output logic [DATA_BITS+ADDR_BITS-1:0] stream_sum
`endif
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, GAP, DONE} state_t;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t               state;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS-1:0] last;
    logic [3:0]           gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            addr             <= '0;
            last             <= '0;
            gap_cnt          <= '0;
            sram_read_enable <= 1'b0;
            sram_address     <= '0;
            stock_price      <= '0;
            data_ready       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
`ifdef PRICE_STREAM_SUM_EN
            stream_sum       <= '0;
`endif
        end else begin
            data_ready <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    addr             <= start_address;
                    last             <= last_address;
                    sram_read_enable <= 1'b1;
                    sram_address     <= start_address;
                    busy             <= 1'b1;
                    state            <= READ;
`ifdef PRICE_STREAM_SUM_EN
                    stream_sum       <= '0;
`endif
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    stock_price <= sram_read_data;
                    data_ready  <= 1'b1;
`ifdef PRICE_STREAM_SUM_EN
                    stream_sum  <= stream_sum + {{ADDR_BITS{1'b0}}, sram_read_data};
`endif
                    if (addr == last) begin
                        done             <= 1'b1;
                        sram_read_enable <= 1'b0;
                        sram_address     <= '0;
                        state            <= DONE;
                    end else if (GAP_CYCLES > 0) begin
                        addr             <= addr + 1'b1;
                        gap_cnt          <= GAP_LAST;
                        sram_read_enable <= 1'b0;
                        sram_address     <= '0;
                        state            <= GAP;
                    end else begin
                        addr         <= addr + 1'b1;
                        sram_address <= addr + 1'b1;
                        state        <= READ;
                    end
                end
                GAP: if (gap_cnt == 4'd0) begin
                    sram_read_enable <= 1'b1;
                    sram_address     <= addr;
                    state            <= READ;
                end else begin
                    gap_cnt <= gap_cnt - 4'd1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_price_streamer.sv
// tb_sram_price_streamer: two instances (no gap, gap of 3) checked each cycle against a window-timing model.
// Also checks stream_sum when PRICE_STREAM_SUM_EN is defined.
module tb_sram_price_streamer;
    localparam int AB = 5;
    localparam int DB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DB-1:0] mem [32];
    logic          st  [2];
    logic [AB-1:0] sa  [2];
    logic [AB-1:0] la  [2];
    logic          re  [2];
    logic [AB-1:0] ad  [2];
    logic [DB-1:0] rd  [2];
    logic [DB-1:0] sp  [2];
    logic          dr  [2];
    logic          bz  [2];
    logic          dn  [2];
`ifdef PRICE_STREAM_SUM_EN
    logic [DB+AB-1:0] sm [2];
`endif

    sram_price_streamer #(.ADDR_BITS(AB), .DATA_BITS(DB), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .start_address(sa[0]), .last_address(la[0]),
        .sram_read_enable(re[0]), .sram_address(ad[0]), .sram_read_data(rd[0]),
        .stock_price(sp[0]), .data_ready(dr[0]), .busy(bz[0]), .done(dn[0])
`ifdef PRICE_STREAM_SUM_EN
        , .stream_sum(sm[0])
`endif
    );

    sram_price_streamer #(.ADDR_BITS(AB), .DATA_BITS(DB), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(st[1]), .start_address(sa[1]), .last_address(la[1]),
        .sram_read_enable(re[1]), .sram_address(ad[1]), .sram_read_data(rd[1]),
        .stock_price(sp[1]), .data_ready(dr[1]), .busy(bz[1]), .done(dn[1])
`ifdef PRICE_STREAM_SUM_EN
        , .stream_sum(sm[1])
`endif
    );

    // Synchronous SRAM: data appears the cycle after the address; garbage when not enabled.
    always @(posedge clk) begin
        rd[0] <= re[0] ? mem[ad[0]] : 32'hDEAD_BEEF;
        rd[1] <= re[1] ? mem[ad[1]] : 32'hDEAD_BEEF;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", name, id, cyc, got, exp);
        end
    endtask

    // Model: a window of n words starting at cycle c0 has word k read at t=1+kP,2+kP and emitted at t=3+kP.
    int            c0   [2];
    int            ms   [2];
    int            mn   [2];
    bit            act  [2];
    logic [DB-1:0] mp   [2];
    logic [63:0]   msum [2];
    int            gap  [2] = '{0, 3};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p, t, td;
            bit e_re, e_dr, e_dn, e_bz;
            logic [AB-1:0] e_ad, dlt;
            p = 2 + gap[i];
            t = cyc - c0[i];
            td = 3 + (mn[i] - 1) * p;
            e_re = 0; e_dr = 0; e_dn = 0; e_bz = 0; e_ad = '0;
            if (rst) begin
                act[i] = 0;
                mp[i] = '0;
                msum[i] = '0;
            end else if (act[i]) begin
                e_bz = (t >= 1 && t <= td);
                if (t >= 1 && (t - 1) % p < 2 && (t - 1) / p < mn[i]) begin
                    e_re = 1;
                    e_ad = AB'(ms[i] + (t - 1) / p);
                end
                if (t >= 3 && (t - 3) % p == 0 && (t - 3) / p < mn[i]) begin
                    e_dr = 1;
                    mp[i] = mem[AB'(ms[i] + (t - 3) / p)];
                    msum[i] = msum[i] + 64'(mp[i]);
                end
                e_dn = (t == td);
            end
            chk("read_enable", i, 64'(re[i]), 64'(e_re));
            chk("address", i, 64'(ad[i]), 64'(e_ad));
            chk("data_ready", i, 64'(dr[i]), 64'(e_dr));
            chk("done", i, 64'(dn[i]), 64'(e_dn));
            chk("busy", i, 64'(bz[i]), 64'(e_bz));
            chk("stock_price", i, 64'(sp[i]), 64'(mp[i]));
`ifdef PRICE_STREAM_SUM_EN
            chk("stream_sum", i, 64'(sm[i]), msum[i]);
`endif
            if (!rst && st[i] && (!act[i] || t > td)) begin
                act[i] = 1;
                c0[i] = cyc;
                ms[i] = int'(sa[i]);
                dlt = la[i] - sa[i];
                mn[i] = int'(dlt) + 1;
                msum[i] = '0;
            end
        end
    end

    task automatic go(input int id, input int s, input int l, output int c);
        @(posedge clk); #1;
        st[id] = 1'b1;
        sa[id] = AB'(s);
        la[id] = AB'(l);
        c = cyc;
        @(posedge clk); #1;
        st[id] = 1'b0;
    endtask

    task automatic at(input int tabs);
        do @(negedge clk); while (cyc < tabs);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c, c1, s0, s1;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        st[0] = 0; st[1] = 0; sa[0] = 0; sa[1] = 0; la[0] = 0; la[1] = 0;
        repeat (3) @(posedge clk);
        at(cyc + 1);
        chk("reset_busy", 0, 64'(bz[0]), 64'd0);
        chk("reset_price", 0, 64'(sp[0]), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        mem[3] = 32'h0000_1234;
        go(0, 3, 3, c);
        at(c + 3);
        chk("single_dr", 0, 64'(dr[0]), 64'd1);
        chk("single_price", 0, 64'(sp[0]), 64'h1234);
        chk("single_done", 0, 64'(dn[0]), 64'd1);
        at(c + 4);
        chk("single_busy_after", 0, 64'(bz[0]), 64'd0);

        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
        go(0, 0, 3, c);
        for (int k = 0; k < 4; k++) begin
            at(c + 3 + 2 * k);
            chk("linear_dr", 0, 64'(dr[0]), 64'd1);
            chk("linear_price", 0, 64'(sp[0]), 64'(10 * (k + 1)));
        end
        chk("linear_done", 0, 64'(dn[0]), 64'd1);
`ifdef PRICE_STREAM_SUM_EN
        chk("sum_first", 0, 64'(sm[0]), 64'd100);
        idle(2);
        go(0, 0, 3, c);
        at(c + 9);
        chk("sum_again", 0, 64'(sm[0]), 64'd100);
`endif
        idle(2);

        mem[30] = 32'hA; mem[31] = 32'hB; mem[0] = 32'hC; mem[1] = 32'hD;
        go(0, 30, 1, c);
        for (int k = 0; k < 4; k++) begin
            at(c + 1 + 2 * k);
            chk("wrap_addr", 0, 64'(ad[0]), 64'((30 + k) % 32));
            at(c + 3 + 2 * k);
            chk("wrap_price", 0, 64'(sp[0]), 64'(10 + k));
        end
        idle(2);

        go(1, 0, 1, c);
        at(c + 3);
        chk("pace_dr1", 1, 64'(dr[1]), 64'd1);
        at(c + 5);
        chk("pace_gap_re", 1, 64'(re[1]), 64'd0);
        at(c + 8);
        chk("pace_dr2", 1, 64'(dr[1]), 64'd1);
        idle(4);

        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40;
        go(0, 0, 3, c);
        while (cyc < c + 6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_dr", 0, 64'(dr[0]), 64'd0);
        chk("rst_re", 0, 64'(re[0]), 64'd0);
        chk("rst_price", 0, 64'(sp[0]), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(6);
        chk("rst_no_done", 0, 64'(dn[0]), 64'd0);
        go(0, 0, 3, c);
        at(c + 3);
        chk("rst_replay", 0, 64'(sp[0]), 64'd10);
        idle(8);

        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            s0 = $urandom_range(0, 31);
            s1 = $urandom_range(0, 31);
            fork
                go(0, s0, (it == 0) ? (s0 + 31) % 32 : (s0 + $urandom_range(0, 12)) % 32, c);
                go(1, s1, (s1 + $urandom_range(0, 12)) % 32, c1);
            join
            idle((it == 0) ? 80 : 75);
        end

        @(posedge clk); #1;
        st[0] = 1'b1; sa[0] = 5; la[0] = 7;
        idle(30);
        st[0] = 1'b0;
        idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
